io_input_port: RTL
==================

Name: io_input_port

Overview:
- Memory-mapped input peripheral on the CPU data bus, alongside the data-memory/IO decoder. It carries traffic from the board to the CPU, the opposite direction to the 7-segment display output path.
- Synchronises and debounces BTNL/BTNR.
- On a BTNR press, latches SW[15:0] into a data register and raises a ready flag. The CPU polls the flag, reads the data, and acknowledges.
- The decoder muxes rdata onto readData when addr selects this block.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before the debounced level changes (10 ms at 100 MHz).
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock (CLK100MHZ domain)
- reset  in  1  asynchronous, active-low reset
- btnl_raw  in  1  raw BTNL pad
- btnr_raw  in  1  raw BTNR pad
- sw_raw  in  16  raw SW pads
- sel  in  1  decoder chip-select for this block
- addr  in  2  word offset, dataAdr[3:2]
- re  in  1  read strobe (load in progress)
- we  in  1  write strobe (Write)
- wdata  in  32  store data
- rdata  out  32  read data, combinational from addr
- irq  out  1  level: ready & ie

Behaviour:
- Reset (reset=0, async): all flops 0, so rdata=0 and irq=0. Debounced levels are 0 and the counters are 0.
- Synchroniser: 2 flops per button and per switch bit.
- Debounce (per button):
  - Counter clears whenever sync==db.
  - Otherwise it increments. When it equals DEBOUNCE_CYCLES-1 and sync still differs from db, db<=sync and the counter clears.
  - Raw change stable from edge k gives db changing at edge k+2+DEBOUNCE_CYCLES.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count and produces no db change.
- Events: a 0->1 transition of db sets its event flag one edge later; 1->0 does nothing.
- Register map (word offset):
  - 0 STATUS: bit0 ready, bit1 ovr, bit2 btnl_evt, bit3 btnr_evt, bit4 ie; others 0.
  - 1 DATA: {16'b0, sw_latched}.
  - 2 CTRL: bit0 ie.
  - 3 reads 0.
- Latch: a btnr_evt set cycle loads sw_latched<=sw_sync and sets ready.
- Read of DATA: sel & re & addr==1 clears ready at the next edge. rdata is combinational and returns the pre-clear value.
- Overrun: a latch while ready=1 sets ovr and overwrites sw_latched with the newest value.
- Simultaneous latch and DATA read in the same cycle:
  - The latch wins: ready stays 1 and sw_latched updates.
  - ovr is not set, because the old value was consumed.
- Writes:
  - STATUS is write-1-to-clear for bits 1..3. Writing bit0 does nothing.
  - CTRL bit0 is plain R/W.
  - Writes to offsets 1 and 3 are ignored.
  - A W1C in the same cycle as a hardware set leaves the flag set (set wins).
- re and we are ignored when sel=0. re and we together: the write applies and the read side effect also applies.
- No bus wait states; every access completes in one cycle.
- Reset mid-debounce: counters and db clear immediately. A held button is re-detected as a fresh press after reset release plus 2+DEBOUNCE_CYCLES edges.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: hold reset=0 with SW=16'hFFFF and buttons high, read all offsets -> rdata=0, irq=0. Release reset -> btnr_evt=1 exactly 7 edges later.
- Glitch reject: btnr_raw high 3 cycles then low -> STATUS stays 0 and ready=0.
- Basic capture: SW=16'hA5C3, press BTNR 10 cycles, then read STATUS -> 32'h9. Read DATA -> 32'h0000A5C3. STATUS then -> 32'h8. Write STATUS 32'h8 -> 0.
- Overrun: capture 16'h1111, then without reading capture 16'h2222 -> STATUS bit1=1 and DATA=16'h2222.
- Race: assert the DATA read on the exact cycle btnr_evt sets with SW=16'h00FF -> ready=1, ovr=0, and the next DATA read returns 16'h00FF.
- IRQ/BTNL: write CTRL=1, press BTNR -> irq=1 until the DATA read. Press BTNL -> bit2=1, ready unchanged, irq unaffected.

Source files
------------

// File: rtl/io_input_port.sv
// io_input_port
//   Memory-mapped input peripheral carrying board inputs (BTNL, BTNR, SW) to
//   the CPU. Buttons are synchronised and debounced; a BTNR press captures the
//   switches into a data register and raises a ready flag that the CPU polls,
//   reads and thereby acknowledges. A rising BTNL is reported as an event flag.
//
//   Ports
//     clk       system clock (CLK100MHZ domain)
//     reset     asynchronous, active-low reset
//     btnl_raw  raw BTNL pad
//     btnr_raw  raw BTNR pad
//     sw_raw    raw SW[15:0] pads
//     sel       decoder chip-select for this block
//     addr      word offset (dataAdr[3:2])
//     re        read strobe
//     we        write strobe
//     wdata     store data
//     rdata     read data, combinational from addr
//     irq       ready & ie
//
//   Register map (word offset)
//     0 STATUS  bit0 ready, bit1 ovr, bit2 btnl_evt, bit3 btnr_evt, bit4 ie
//               (bits 1..3 write-1-to-clear)
//     1 DATA    {16'b0, sw_latched}; reading it clears ready
//     2 CTRL    bit0 ie
//     3 reads 0
module io_input_port #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnl_raw,
  input  logic        btnr_raw,
  input  logic [15:0] sw_raw,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button index 0 is BTNL, index 1 is BTNR.
  logic [1:0]       btn_s1;
  logic [1:0]       btn_s2;
  logic [1:0]       db;
  logic [1:0]       db_d;
  logic [CNT_W-1:0] cnt [2];
  logic [15:0]      sw_s1;
  logic [15:0]      sw_s2;

  logic [15:0] sw_latched;
  logic        ready;
  logic        ovr;
  logic        btnl_evt;
  logic        btnr_evt;
  logic        ie;

  logic [1:0] rise;
  logic       latch;
  logic       rd_data;
  logic       wr_status;
  logic       wr_ctrl;
  logic       unused_wdata;

  // Two-flop synchronisers for both buttons and every switch bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= {btnr_raw, btnl_raw};
      btn_s2 <= btn_s1;
      sw_s1  <= sw_raw;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce: the counter only runs while the synchronised level disagrees
  // with the debounced one, so any glitch that flips back early clears it.
  // db_d delays db by one edge to detect the debounced rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (btn_s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= btn_s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise      = db & ~db_d;
  assign latch     = rise[1];
  assign rd_data   = sel & re & (addr == 2'd1);
  assign wr_status = sel & we & (addr == 2'd0);
  assign wr_ctrl   = sel & we & (addr == 2'd2);

  // Capture and flag registers. Hardware sets take priority over software
  // clears. A capture coinciding with a DATA read keeps ready set and does
  // not count as an overrun, since the previous value was consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_latched <= '0;
      ready      <= 1'b0;
      ovr        <= 1'b0;
      btnl_evt   <= 1'b0;
      btnr_evt   <= 1'b0;
      ie         <= 1'b0;
    end else begin
      if (latch) begin
        sw_latched <= sw_s2;
        ready      <= 1'b1;
      end else if (rd_data) begin
        ready <= 1'b0;
      end

      if (latch && ready && !rd_data) begin
        ovr <= 1'b1;
      end else if (wr_status && wdata[1]) begin
        ovr <= 1'b0;
      end

      if (rise[0]) begin
        btnl_evt <= 1'b1;
      end else if (wr_status && wdata[2]) begin
        btnl_evt <= 1'b0;
      end

      if (rise[1]) begin
        btnr_evt <= 1'b1;
      end else if (wr_status && wdata[3]) begin
        btnr_evt <= 1'b0;
      end

      if (wr_ctrl) begin
        ie <= wdata[0];
      end
    end
  end

  // Read mux is purely combinational from addr; the decoder qualifies it.
  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata = {27'b0, ie, btnr_evt, btnl_evt, ovr, ready};
      2'd1:    rdata = {16'b0, sw_latched};
      2'd2:    rdata = {31'b0, ie};
      default: rdata = '0;
    endcase
  end

  assign irq = ready & ie;

  assign unused_wdata = ^wdata[31:4];

endmodule
